// File: rtl/dac_spi_frame_capture.sv
// DAC serial-link receive monitor: oversampled SYNC/SCLK/DIN deserializer with FWFT FIFO.
// Optional DAC_CAPTURE_STATS_EN adds frame_count / err_count outputs.
module dac_spi_frame_capture #(
    parameter int FRAME_BITS = 24,
    parameter int DATA_BITS  = 16,
    parameter int FIFO_AW    = 2
) (
    input  logic                            dataclk,
    input  logic                            reset_n,
    input  logic                            DAC_SYNC,
    input  logic                            DAC_SCLK,
    input  logic                            DAC_DIN,
    input  logic                            rd_en,
    input  logic                            clr_flags,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic [FRAME_BITS-DATA_BITS-1:0] rd_ctrl,
    output logic                            frame_valid,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic                            err_short,
    output logic                            err_long,
    output logic                            err_overflow
`ifdef DAC_CAPTURE_STATS_EN
    ,
    output logic [15:0]                     frame_count,
    output logic [7:0]                      err_count
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // Sync flops reset low so a SYNC already low at release never looks like a fall.
    logic [2:0] sync_q;
    logic [2:0] sclk_q;
    logic [1:0] din_q;

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            sclk_q <= '0;
            din_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], DAC_SYNC};
            sclk_q <= {sclk_q[1:0], DAC_SCLK};
            din_q  <= {din_q[0], DAC_DIN};
        end
    end

    logic sclk_fall;
    logic sync_fall;
    logic sync_rise;
    logic din_s;

    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign sync_fall = sync_q[2] & ~sync_q[1];
    assign sync_rise = ~sync_q[2] & sync_q[1];
    assign din_s     = din_q[1];

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-2:0] shreg_q, shreg_d;
    logic                  push_req;
    logic                  set_short;
    logic                  set_long;
    logic                  set_ovf;
    logic [FRAME_BITS-1:0] frame_word;

    assign frame_word = {shreg_q, din_s};

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sync_fall) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            S_SHIFT: begin
                if (sclk_fall) begin
                    shreg_d = frame_word[FRAME_BITS-2:0];
                    cnt_d   = cnt_q + 1'b1;
                end
                // A final edge coinciding with SYNC rise still completes the frame.
                if (sclk_fall && cnt_q == LAST) begin
                    push_req = 1'b1;
                    state_d  = sync_rise ? S_IDLE : S_DONE;
                end else if (sync_rise) begin
                    set_short = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                if (sclk_fall) set_long = 1'b1;
                if (sync_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW:0]      wr_ptr;
    logic [FIFO_AW:0]      rd_ptr;
    logic                  pop;
    logic                  push;
    logic [FRAME_BITS-1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop        = rd_en & ~fifo_empty;
    assign push       = push_req & (~fifo_full | pop);
    assign set_ovf    = push_req & fifo_full & ~pop;
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign rd_data    = fifo_empty ? '0 : head[DATA_BITS-1:0];
    assign rd_ctrl    = fifo_empty ? '0 : head[FRAME_BITS-1:DATA_BITS];

    always_ff @(posedge dataclk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= frame_word;
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_valid  <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            frame_valid  <= push;
            err_short    <= set_short | (err_short & ~clr_flags);
            err_long     <= set_long | (err_long & ~clr_flags);
            err_overflow <= set_ovf | (err_overflow & ~clr_flags);
        end
    end

`ifdef DAC_CAPTURE_STATS_EN
    logic err_inc;

    assign err_inc = set_short | set_long | set_ovf;

    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_count <= (clr_flags ? 16'd0 : frame_count) + {15'd0, push_req};
            if (clr_flags) begin
                err_count <= {7'd0, err_inc};
            end else if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dac_spi_frame_capture.sv
// Directed bench for dac_spi_frame_capture: framing, errors, FIFO depth and reset.
module tb_dac_spi_frame_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_pin;
    logic        sclk_pin;
    logic        din_pin;
    logic        rd_en;
    logic        clr_flags;
    logic [15:0] rd_data;
    logic [7:0]  rd_ctrl;
    logic        frame_valid;
    logic        fifo_empty;
    logic        fifo_full;
    logic        err_short;
    logic        err_long;
    logic        err_overflow;
`ifdef DAC_CAPTURE_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int fv_cnt  = 0;
    int fv_base;

    always #5 clk = ~clk;

    dac_spi_frame_capture dut (
        .dataclk      (clk),
        .reset_n      (reset_n),
        .DAC_SYNC     (sync_pin),
        .DAC_SCLK     (sclk_pin),
        .DAC_DIN      (din_pin),
        .rd_en        (rd_en),
        .clr_flags    (clr_flags),
        .rd_data      (rd_data),
        .rd_ctrl      (rd_ctrl),
        .frame_valid  (frame_valid),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .err_short    (err_short),
        .err_long     (err_long),
        .err_overflow (err_overflow)
`ifdef DAC_CAPTURE_STATS_EN
        ,
        .frame_count  (frame_count),
        .err_count    (err_count)
`endif
    );

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // MSB first; optional rd_en pulse timed to the push of the final bit.
    task automatic send_bits(input logic [31:0] bits, input int n, input bit pop_last);
        for (int i = n - 1; i >= 0; i--) begin
            din_pin  = bits[i];
            sclk_pin = 1'b1;
            tick(6);
            sclk_pin = 1'b0;
            if (pop_last && i == 0) begin
                tick(2);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                tick(3);
            end else begin
                tick(6);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input bit pop_last);
        sync_pin = 1'b0;
        tick(6);
        send_bits(bits, n, pop_last);
        tick(2);
        sync_pin = 1'b1;
        tick(8);
    endtask

    task automatic pop_word;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        sync_pin  = 1'b1;
        sclk_pin  = 1'b0;
        din_pin   = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(4);

        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_flags", {err_short, err_long, err_overflow}, 0);
        chk("rst_data", {rd_ctrl, rd_data}, 0);

        // Basic frame
        fv_base = fv_cnt;
        send_frame({8'h00, 16'h7777}, 24, 0);
        chk("basic_fv", fv_cnt - fv_base, 1);
        chk("basic_data", rd_data, 16'h7777);
        chk("basic_ctrl", rd_ctrl, 8'h00);
        chk("basic_empty", fifo_empty, 0);
        pop_word();
        chk("basic_pop_empty", fifo_empty, 1);
        pop_word();
        chk("empty_pop_ignored", fifo_empty, 1);

        // Short frame
        fv_base = fv_cnt;
        send_frame(32'h2AA, 10, 0);
        chk("short_err", err_short, 1);
        chk("short_empty", fifo_empty, 1);
        chk("short_fv", fv_cnt - fv_base, 0);
        clear_flags();
        chk("short_clr", err_short, 0);
        send_frame({8'h12, 16'h5A5A}, 24, 0);
        chk("after_short_data", {rd_ctrl, rd_data}, 24'h125A5A);
        chk("after_short_flags", {err_short, err_long, err_overflow}, 0);
        pop_word();

        // Overflow: five frames into a four-deep FIFO
        fv_base = fv_cnt;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] c;
            logic [15:0] d;
            c = 8'hA0 + 8'(i);
            d = 16'(i);
            send_frame({c, d}, 24, 0);
        end
        chk("ovf_full", fifo_full, 1);
        chk("ovf_err", err_overflow, 1);
        chk("ovf_fv", fv_cnt - fv_base, 4);
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] c;
            logic [15:0] d;
            c = 8'hA0 + 8'(i);
            d = 16'(i);
            chk("ovf_head", {rd_ctrl, rd_data}, {8'h0, c, d});
            pop_word();
        end
        chk("ovf_drained", fifo_empty, 1);
        clear_flags();
        chk("ovf_clr", err_overflow, 0);

        // Long frame: 26 falls
        send_frame({6'h0, 8'h3C, 16'hABCD, 2'b10}, 26, 0);
        chk("long_err", err_long, 1);
        chk("long_data", rd_data, 16'hABCD);
        chk("long_ctrl", rd_ctrl, 8'h3C);
        chk("long_short", err_short, 0);
        pop_word();
        clear_flags();
        chk("long_clr", err_long, 0);

        // Reset mid-frame flushes FIFO and ignores the frame in progress
        send_frame({8'h99, 16'h1234}, 24, 0);
        chk("pre_rst_empty", fifo_empty, 0);
        fv_base = fv_cnt;
        sync_pin = 1'b0;
        tick(6);
        send_bits(32'hF0F, 12, 0);
        reset_n = 1'b0;
        tick(3);
        chk("midrst_empty", fifo_empty, 1);
        reset_n = 1'b1;
        tick(3);
        send_bits(32'hF0F, 12, 0);
        tick(2);
        sync_pin = 1'b1;
        tick(8);
        chk("midrst_no_cap", fifo_empty, 1);
        chk("midrst_fv", fv_cnt - fv_base, 0);
        chk("midrst_flags", {err_short, err_long, err_overflow}, 0);
        send_frame({8'h55, 16'h0F0F}, 24, 0);
        chk("midrst_next", {rd_ctrl, rd_data}, 24'h550F0F);
        pop_word();

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) send_frame({8'h40, 16'h10 + 16'(i)}, 24, 0);
        chk("pp_full_pre", fifo_full, 1);
        send_frame({8'h40, 16'h0014}, 24, 1);
        chk("pp_no_ovf", err_overflow, 0);
        chk("pp_full", fifo_full, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("pp_head", rd_data, 16'h10 + 16'(i));
            pop_word();
        end
        chk("pp_drained", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
